// File: rtl/e_mod_addsub_seq_if.sv
// Request/response bundle for the modular add/subtract sequencer.
//   start  - request pulse, sampled with op_i/x_i/y_i while busy_o is low
//   op_i   - 0 = add, 1 = subtract
//   x_i    - operand x (expected < P)
//   y_i    - operand y (expected < P)
//   busy_o - operation in flight, through the done cycle inclusive
//   done_o - one-cycle pulse, r_o valid
//   r_o    - result, held until the next done_o
//   err_o  - out-of-range operand flag (only with E_MOD_ADDSUB_RANGE_CHK_EN)
// master: requester side; slave: sequencer side.
interface e_mod_addsub_seq_if;
    logic         start;
    logic         op_i;
    logic [255:0] x_i;
    logic [255:0] y_i;
    logic         busy_o;
    logic         done_o;
    logic [255:0] r_o;
`ifdef E_MOD_ADDSUB_RANGE_CHK_EN
    logic         err_o;
`endif

    modport master (
        output start, op_i, x_i, y_i,
        input  busy_o, done_o, r_o
`ifdef E_MOD_ADDSUB_RANGE_CHK_EN
        , err_o
`endif
    );

    modport slave (
        input  start, op_i, x_i, y_i,
        output busy_o, done_o, r_o
`ifdef E_MOD_ADDSUB_RANGE_CHK_EN
        , err_o
`endif
    );
endinterface

// File: rtl/e_mod_addsub_seq.sv
// Sequencer around an external pipelined 256-bit adder computing
// r = (x + y) mod P or r = (x - y) mod P using one or two adder passes.
// Adder operands are registered and held for ADD_LAT+1 cycles per pass because
// the adder's final stage is combinational from its inputs.
// Ports:
//   clk, reset - clock, synchronous active-high reset (shared with the adder)
//   req        - request/response bundle (slave modport)
//   add_a_o, add_b_o, add_c_o - registered adder operands / carry-in
//   add_s_i, add_c_i          - adder sum / carry-out
// Optional: define E_MOD_ADDSUB_RANGE_CHK_EN to add req.err_o and reject
// operands >= P with r_o = 0.
module e_mod_addsub_seq #(
    parameter int unsigned  ADD_LAT = 8,
    parameter logic [255:0] P       =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    e_mod_addsub_seq_if.slave     req,
    output logic [255:0]          add_a_o,
    output logic [255:0]          add_b_o,
    output logic                  add_c_o,
    input  logic [255:0]          add_s_i,
    input  logic                  add_c_i
);

    localparam int unsigned      CntW    = $clog2(ADD_LAT + 1);
    localparam logic [CntW-1:0]  CntLast = CntW'(ADD_LAT);

    typedef enum logic [1:0] {StIdle, StPass1, StPass2, StFin} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            op_q;
    logic            c1_q;
    logic            bad_q;
    logic            busy_q;
    logic            done_q;
    logic [255:0]    r_q;
    logic [255:0]    add_a_q;
    logic [255:0]    add_b_q;
    logic            add_c_q;
    logic            range_bad;

`ifdef E_MOD_ADDSUB_RANGE_CHK_EN
    assign range_bad  = (req.x_i >= P) || (req.y_i >= P);
    assign req.err_o  = done_q & bad_q;
`else
    assign range_bad  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            c1_q    <= 1'b0;
            bad_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            r_q     <= '0;
            add_a_q <= '0;
            add_b_q <= '0;
            add_c_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req.start) begin
                        op_q    <= req.op_i;
                        bad_q   <= range_bad;
                        busy_q  <= 1'b1;
                        state_q <= StPass1;
                        // Subtraction is x + ~y + 1.
                        add_a_q <= req.x_i;
                        add_b_q <= req.op_i ? ~req.y_i : req.y_i;
                        add_c_q <= req.op_i;
                        // A rejected request jumps straight to the decision
                        // point so done_o lands one cycle later.
                        cnt_q   <= range_bad ? CntLast : '0;
                    end
                end
                StPass1: begin
                    if (cnt_q == CntLast) begin
                        cnt_q <= '0;
                        if (bad_q) begin
                            r_q     <= '0;
                            done_q  <= 1'b1;
                            state_q <= StFin;
                        end else if (!op_q) begin
                            // t = s1 - P; carry-out of 1 means no borrow.
                            c1_q    <= add_c_i;
                            add_a_q <= add_s_i;
                            add_b_q <= ~P;
                            add_c_q <= 1'b1;
                            state_q <= StPass2;
                        end else if (add_c_i) begin
                            r_q     <= add_s_i;
                            done_q  <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            // Borrow: wrap back into the field by adding P.
                            add_a_q <= add_s_i;
                            add_b_q <= P;
                            add_c_q <= 1'b0;
                            state_q <= StPass2;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StPass2: begin
                    if (cnt_q == CntLast) begin
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= StFin;
                        if (op_q) begin
                            r_q <= add_s_i;
                        end else begin
                            // add_a_q still holds s1 from pass 1.
                            r_q <= (c1_q | add_c_i) ? add_s_i : add_a_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StFin: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req.busy_o = busy_q;
    assign req.done_o = done_q;
    assign req.r_o    = r_q;
    assign add_a_o    = add_a_q;
    assign add_b_o    = add_b_q;
    assign add_c_o    = add_c_q;

endmodule

// File: tb/tb_e_mod_addsub_seq.sv
// Directed bench for e_mod_addsub_seq with a behavioural adder that only
// returns the true sum once its operands have been held for ADD_LAT edges.
module tb_e_mod_addsub_seq;

    localparam int unsigned  ADD_LAT = 8;
    localparam logic [255:0] P =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

    logic         clk;
    logic         reset;
    logic [255:0] add_a;
    logic [255:0] add_b;
    logic         add_c;
    logic [255:0] add_s;
    logic         add_co;

    int checks;
    int passes;

    e_mod_addsub_seq_if bus ();

    e_mod_addsub_seq #(
        .ADD_LAT (ADD_LAT),
        .P       (P)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.slave),
        .add_a_o (add_a),
        .add_b_o (add_b),
        .add_c_o (add_c),
        .add_s_i (add_s),
        .add_c_i (add_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: output is garbage (inverted sum) until inputs are stable.
    logic [255:0] a_prev;
    logic [255:0] b_prev;
    logic         c_prev;
    int unsigned  held;
    logic [256:0] true_sum;

    always @(posedge clk) begin
        if (reset) begin
            held   <= 0;
            a_prev <= '0;
            b_prev <= '0;
            c_prev <= 1'b0;
        end else begin
            if (add_a === a_prev && add_b === b_prev && add_c === c_prev) begin
                if (held < 1000) held <= held + 1;
            end else begin
                held <= 1;
            end
            a_prev <= add_a;
            b_prev <= add_b;
            c_prev <= add_c;
        end
    end

    always_comb begin
        true_sum = {1'b0, add_a} + {1'b0, add_b} + {256'd0, add_c};
        if (held >= ADD_LAT) {add_co, add_s} = true_sum;
        else                 {add_co, add_s} = ~true_sum;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a request in the current cycle (cycle 0); return the cycle of done_o
    // (-1 on timeout) and r_o. Returns positioned one cycle after done_o.
    task automatic run_op(input logic op, input logic [255:0] x, input logic [255:0] y,
                          output int dcyc, output logic [255:0] r);
        int c;
        dcyc = -1;
        r = '0;
        bus.start = 1'b1;
        bus.op_i  = op;
        bus.x_i   = x;
        bus.y_i   = y;
        step();
        bus.start = 1'b0;
        c = 1;
        while (dcyc < 0 && c <= 60) begin
            if (bus.done_o === 1'b1) begin
                dcyc = c;
                r = bus.r_o;
            end
            step();
            c++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.r_o !== '0 ||
            add_a !== '0 || add_b !== '0 || add_c !== 1'b0) begin
            $display("FAIL reset_state: busy=%b done=%b r=%h a=%h b=%h c=%b required all 0",
                     bus.busy_o, bus.done_o, bus.r_o, add_a, add_b, add_c);
        end else passes++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_add_basic();
        logic [255:0] a0, b0;
        logic         c0;
        logic         st1, st2;
        int           dcyc;
        logic [255:0] r;
        logic [255:0] not_p;
        not_p = ~P;
        st1 = 1'b1;
        st2 = 1'b1;
        dcyc = -1;
        r = '0;
        a0 = '0;
        b0 = '0;
        c0 = 1'b0;
        bus.start = 1'b1;
        bus.op_i  = 1'b0;
        bus.x_i   = 256'd1;
        bus.y_i   = 256'd2;
        checks++;
        if (bus.busy_o !== 1'b0) $display("FAIL busy_idle: got %b required 0", bus.busy_o);
        else passes++;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 1) begin
                a0 = add_a; b0 = add_b; c0 = add_c;
                checks++;
                if (bus.busy_o !== 1'b1) $display("FAIL busy_c1: got %b required 1", bus.busy_o);
                else passes++;
                checks++;
                if (a0 !== 256'd1 || b0 !== 256'd2 || c0 !== 1'b0)
                    $display("FAIL pass1_ops: got %h %h %b required 1 2 0", a0, b0, c0);
                else passes++;
            end
            if (c >= 2 && c <= 9 && (add_a !== a0 || add_b !== b0 || add_c !== c0)) st1 = 1'b0;
            if (c == 10) begin
                a0 = add_a; b0 = add_b; c0 = add_c;
                checks++;
                if (a0 !== 256'd3 || b0 !== not_p || c0 !== 1'b1)
                    $display("FAIL pass2_ops: got %h %h %b required 3 %h 1", a0, b0, c0, not_p);
                else passes++;
            end
            if (c >= 11 && c <= 18 && (add_a !== a0 || add_b !== b0 || add_c !== c0)) st2 = 1'b0;
            if (c == 19) begin
                checks++;
                if (bus.busy_o !== 1'b1) $display("FAIL busy_done: got %b required 1", bus.busy_o);
                else passes++;
            end
            if (c == 20) begin
                checks++;
                if (bus.busy_o !== 1'b0) $display("FAIL busy_after: got %b required 0", bus.busy_o);
                else passes++;
            end
            if (bus.done_o === 1'b1 && dcyc < 0) begin
                dcyc = c;
                r = bus.r_o;
            end
            step();
        end
        checks++;
        if (!st1) $display("FAIL pass1_stable: got 0 required 1"); else passes++;
        checks++;
        if (!st2) $display("FAIL pass2_stable: got 0 required 1"); else passes++;
        checks++;
        if (dcyc != 19) $display("FAIL add_1_2_cycle: got %0d required 19", dcyc); else passes++;
        checks++;
        if (r !== 256'd3) $display("FAIL add_1_2_result: got %h required 3", r); else passes++;
    endtask

    task automatic test_add_wrap();
        int           dcyc;
        logic [255:0] r;
        run_op(1'b0, P - 256'd1, 256'd2, dcyc, r);
        checks++;
        if (dcyc != 19 || r !== 256'd1)
            $display("FAIL add_pm1_2: got cycle %0d r=%h required 19 r=1", dcyc, r);
        else passes++;
        run_op(1'b0, P - 256'd1, P - 256'd1, dcyc, r);
        checks++;
        if (dcyc != 19 || r !== P - 256'd2)
            $display("FAIL add_pm1_pm1: got cycle %0d r=%h required 19 r=%h", dcyc, r, P - 256'd2);
        else passes++;
    endtask

    task automatic test_sub();
        int           dcyc;
        logic [255:0] r;
        logic [255:0] not3;
        not3 = ~256'd3;
        run_op(1'b1, 256'd5, 256'd3, dcyc, r);
        checks++;
        if (dcyc != 10 || r !== 256'd2)
            $display("FAIL sub_5_3: got cycle %0d r=%h required 10 r=2", dcyc, r);
        else passes++;
        checks++;
        if (add_b !== not3 || add_c !== 1'b1)
            $display("FAIL sub_single_pass: got b=%h c=%b required %h 1", add_b, add_c, not3);
        else passes++;
        run_op(1'b1, 256'd3, 256'd5, dcyc, r);
        checks++;
        if (dcyc != 19 || r !== P - 256'd2)
            $display("FAIL sub_3_5: got cycle %0d r=%h required 19 r=%h", dcyc, r, P - 256'd2);
        else passes++;
        checks++;
        if (add_b !== P || add_c !== 1'b0)
            $display("FAIL sub_pass2_ops: got b=%h c=%b required %h 0", add_b, add_c, P);
        else passes++;
    endtask

    // Runs after test_sub, so r_o starts at P-2.
    task automatic test_back_to_back();
        int           ndone;
        int           d1, d2;
        logic [255:0] r1, r2;
        logic         hold_ok;
        ndone = 0;
        d1 = -1; d2 = -1;
        r1 = '0; r2 = '0;
        hold_ok = 1'b1;
        bus.start = 1'b1;
        bus.op_i  = 1'b0;
        bus.x_i   = 256'd10;
        bus.y_i   = 256'd20;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 3 || c == 19) begin
                bus.start = 1'b1; bus.op_i = 1'b1; bus.x_i = 256'd555; bus.y_i = 256'd1;
            end
            if (c == 4) bus.start = 1'b0;
            if (c == 20) begin
                bus.start = 1'b1; bus.op_i = 1'b0; bus.x_i = 256'd100; bus.y_i = 256'd200;
            end
            if (c == 21) bus.start = 1'b0;
            if (c <= 18 && bus.r_o !== P - 256'd2) hold_ok = 1'b0;
            if (c >= 20 && c <= 38 && bus.r_o !== 256'd30) hold_ok = 1'b0;
            if (bus.done_o === 1'b1) begin
                ndone++;
                if (d1 < 0) begin d1 = c; r1 = bus.r_o; end
                else if (d2 < 0) begin d2 = c; r2 = bus.r_o; end
            end
            step();
        end
        checks++;
        if (d1 != 19 || r1 !== 256'd30)
            $display("FAIL b2b_first: got cycle %0d r=%h required 19 r=1e", d1, r1);
        else passes++;
        checks++;
        if (d2 != 39 || r2 !== 256'd300)
            $display("FAIL b2b_second: got cycle %0d r=%h required 39 r=12c", d2, r2);
        else passes++;
        checks++;
        if (ndone != 2) $display("FAIL b2b_done_count: got %0d required 2", ndone); else passes++;
        checks++;
        if (!hold_ok) $display("FAIL r_hold: got 0 required 1"); else passes++;
    endtask

    task automatic test_reset_mid();
        int           ndone;
        int           dcyc;
        logic [255:0] r;
        ndone = 0;
        bus.start = 1'b1;
        bus.op_i  = 1'b0;
        bus.x_i   = 256'd1;
        bus.y_i   = 256'd1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (bus.done_o === 1'b1) ndone++;
            if (c == 12) reset = 1'b1;
            if (c == 13) begin
                reset = 1'b0;
                checks++;
                if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.r_o !== '0 ||
                    add_a !== '0 || add_b !== '0 || add_c !== 1'b0)
                    $display("FAIL reset_mid_state: busy=%b done=%b r=%h a=%h b=%h c=%b required 0",
                             bus.busy_o, bus.done_o, bus.r_o, add_a, add_b, add_c);
                else passes++;
            end
            step();
        end
        checks++;
        if (ndone != 0) $display("FAIL reset_mid_no_done: got %0d required 0", ndone); else passes++;
        run_op(1'b0, 256'd7, 256'd8, dcyc, r);
        checks++;
        if (dcyc != 19 || r !== 256'd15)
            $display("FAIL add_7_8: got cycle %0d r=%h required 19 r=f", dcyc, r);
        else passes++;
    endtask

`ifdef E_MOD_ADDSUB_RANGE_CHK_EN
    task automatic test_range();
        logic [255:0] xs [2];
        logic [255:0] ys [2];
        logic [255:0] rexp [2];
        int           dexp [2];
        logic         eexp [2];
        int           dcyc;
        logic [255:0] r;
        logic         e;
        xs[0] = P;            ys[0] = 256'd1; rexp[0] = '0;           dexp[0] = 2;  eexp[0] = 1'b1;
        xs[1] = P - 256'd1;   ys[1] = 256'd0; rexp[1] = P - 256'd1;   dexp[1] = 19; eexp[1] = 1'b0;
        for (int v = 0; v < 2; v++) begin
            dcyc = -1; r = '0; e = 1'b0;
            bus.start = 1'b1; bus.op_i = 1'b0; bus.x_i = xs[v]; bus.y_i = ys[v];
            step();
            bus.start = 1'b0;
            for (int c = 1; c <= 25; c++) begin
                if (bus.done_o === 1'b1 && dcyc < 0) begin
                    dcyc = c; r = bus.r_o; e = bus.err_o;
                end else if (bus.err_o !== 1'b0) begin
                    e = 1'b1;
                end
                step();
            end
            checks++;
            if (dcyc != dexp[v] || r !== rexp[v] || e !== eexp[v])
                $display("FAIL range_%0d: got cycle %0d r=%h err=%b required %0d r=%h err=%b",
                         v, dcyc, r, e, dexp[v], rexp[v], eexp[v]);
            else passes++;
        end
    endtask
`endif

    initial begin
        checks    = 0;
        passes    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op_i  = 1'b0;
        bus.x_i   = '0;
        bus.y_i   = '0;
        #1;
        test_reset();
        test_add_basic();
        test_add_wrap();
        test_sub();
        test_back_to_back();
        test_reset_mid();
`ifdef E_MOD_ADDSUB_RANGE_CHK_EN
        test_range();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
